eth_rx_buf_ctrl: RTL and testbench

Receive-side controller for the Ethernet dual-port frame buffer (16-bit port A, 64-bit port B, 4 KB). It takes the MAC receive byte stream and writes each byte into the buffer's 16-bit port with byte enables. It manages the buffer as a ring of equal-size frame slots and publishes committed frames (slot index and byte length) to the host, which reads them through the 64-bit port. It also drops frames that cannot be stored and counts them.

---
 rtl/eth_rx_buf_ctrl.sv | 146 ++++++++++++++
 tb/tb_eth_rx_buf_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_buf_ctrl.sv
// Receive-side controller for the Ethernet frame buffer: writes MAC bytes into
// port A of the dual-port RAM and publishes committed frames from a slot ring.
module eth_rx_buf_ctrl #(
  parameter int SLOT_BITS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  input  logic                 rx_last_i,
  input  logic                 rx_err_i,
  output logic                 buf_en_o,
  output logic [1:0]           buf_we_o,
  output logic [10:0]          buf_addr_o,
  output logic [15:0]          buf_wdata_o,
  output logic                 frame_avail_o,
  output logic [SLOT_BITS-1:0] frame_slot_o,
  output logic [11:0]          frame_len_o,
  input  logic                 frame_done_i,
  output logic [15:0]          drop_cnt_o
);
  localparam int          NSLOT      = 1 << SLOT_BITS;
  localparam logic [11:0] SLOT_BYTES = 12'(1 << (12 - SLOT_BITS));

  typedef enum logic [1:0] {IDLE, RECV, DISCARD, COMMIT} state_t;

  state_t               state, state_next;
  logic [SLOT_BITS-1:0] wr_ptr, rd_ptr, wr_ptr_next, rd_ptr_next;
  logic [SLOT_BITS:0]   count, count_next;
  logic [11:0]          len [NSLOT];
  logic [11:0]          byte_idx, widx, head_len_next;
  logic                 accept, drop, commit, rel, ring_full;

  // count never exceeds NSLOT, so its top bit alone marks a full ring
  assign ring_full = count[SLOT_BITS];
  assign widx      = (state == IDLE) ? 12'd0 : byte_idx;

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (rx_valid_i) begin
          if (ring_full) begin
            state_next = rx_last_i ? IDLE : DISCARD;
            drop       = rx_last_i;
          end else begin
            accept = 1'b1;
            if (rx_last_i) begin
              state_next = rx_err_i ? IDLE : COMMIT;
              drop       = rx_err_i;
            end else begin
              state_next = RECV;
            end
          end
        end
      end
      RECV: begin
        if (rx_valid_i) begin
          if (byte_idx == SLOT_BYTES) begin
            state_next = rx_last_i ? IDLE : DISCARD;
            drop       = rx_last_i;
          end else begin
            accept = 1'b1;
            if (rx_last_i) begin
              state_next = rx_err_i ? IDLE : COMMIT;
              drop       = rx_err_i;
            end
          end
        end
      end
      DISCARD: begin
        if (rx_valid_i && rx_last_i) begin
          state_next = IDLE;
          drop       = 1'b1;
        end
      end
      default: begin
        // a byte landing in the commit cycle cannot be placed; drop its frame
        state_next = IDLE;
        if (rx_valid_i) begin
          state_next = rx_last_i ? IDLE : DISCARD;
          drop       = rx_last_i;
        end
      end
    endcase
  end

  always_comb begin
    commit      = (state == COMMIT);
    rel         = frame_done_i && (count != '0);
    wr_ptr_next = commit ? wr_ptr + 1'b1 : wr_ptr;
    rd_ptr_next = rel ? rd_ptr + 1'b1 : rd_ptr;
    count_next  = count;
    if (commit && !rel) begin
      count_next = count + 1'b1;
    end else if (!commit && rel) begin
      count_next = count - 1'b1;
    end
    // the length being committed is not in len[] yet when it becomes the head
    head_len_next = (commit && (rd_ptr_next == wr_ptr)) ? byte_idx : len[rd_ptr_next];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      byte_idx      <= '0;
      for (int i = 0; i < NSLOT; i++) begin
        len[i] <= '0;
      end
      buf_en_o      <= 1'b0;
      buf_we_o      <= 2'b00;
      buf_addr_o    <= '0;
      buf_wdata_o   <= '0;
      frame_avail_o <= 1'b0;
      frame_slot_o  <= '0;
      frame_len_o   <= '0;
      drop_cnt_o    <= '0;
    end else begin
      state    <= state_next;
      buf_en_o <= accept;
      buf_we_o <= accept ? (widx[0] ? 2'b10 : 2'b01) : 2'b00;
      if (accept) begin
        buf_addr_o  <= {wr_ptr, widx[11-SLOT_BITS:1]};
        buf_wdata_o <= {rx_data_i, rx_data_i};
        byte_idx    <= widx + 12'd1;
      end
      if (commit) begin
        len[wr_ptr] <= byte_idx;
      end
      wr_ptr <= wr_ptr_next;
      rd_ptr <= rd_ptr_next;
      count  <= count_next;
      if (drop && (drop_cnt_o != 16'hFFFF)) begin
        drop_cnt_o <= drop_cnt_o + 16'd1;
      end
      frame_avail_o <= (count_next != '0);
      frame_slot_o  <= rd_ptr_next;
      frame_len_o   <= head_len_next;
    end
  end
endmodule

// File: tb/tb_eth_rx_buf_ctrl.sv
// Bench for eth_rx_buf_ctrl: frame-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_eth_rx_buf_ctrl;
  localparam int SLOT_BITS  = 1;
  localparam int NSLOT      = 2;
  localparam int SLOT_BYTES = 2048;
  localparam int SLOT_WORDS = 1024;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 rx_valid_i = 1'b0;
  logic [7:0]           rx_data_i = 8'h00;
  logic                 rx_last_i = 1'b0;
  logic                 rx_err_i = 1'b0;
  logic                 frame_done_i = 1'b0;
  logic                 buf_en_o;
  logic [1:0]           buf_we_o;
  logic [10:0]          buf_addr_o;
  logic [15:0]          buf_wdata_o;
  logic                 frame_avail_o;
  logic [SLOT_BITS-1:0] frame_slot_o;
  logic [11:0]          frame_len_o;
  logic [15:0]          drop_cnt_o;

  int checks = 0;
  int failures = 0;

  eth_rx_buf_ctrl #(.SLOT_BITS(SLOT_BITS)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i),
    .rx_last_i(rx_last_i), .rx_err_i(rx_err_i),
    .buf_en_o(buf_en_o), .buf_we_o(buf_we_o),
    .buf_addr_o(buf_addr_o), .buf_wdata_o(buf_wdata_o),
    .frame_avail_o(frame_avail_o), .frame_slot_o(frame_slot_o),
    .frame_len_o(frame_len_o), .frame_done_i(frame_done_i),
    .drop_cnt_o(drop_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  int q_slot[$];
  int q_len[$];
  int wr_slot, rd_slot, mode, cur_len, commit_len, drops;
  bit commit_pend;
  bit e_en;
  int e_we, e_addr, e_wdata;

  task automatic model_reset();
    q_slot.delete(); q_len.delete();
    wr_slot = 0; rd_slot = 0; mode = 0; cur_len = 0; commit_len = 0;
    drops = 0; commit_pend = 0; e_en = 0; e_we = 0; e_addr = 0; e_wdata = 0;
  endtask

  task automatic add_drop();
    if (drops < 65535) drops++;
  endtask

  task automatic discard_start();
    if (rx_last_i) begin
      add_drop();
      mode = 0;
    end else begin
      mode = 2;
    end
  endtask

  task automatic accept_byte(output bit nc);
    nc      = 0;
    e_en    = 1;
    e_we    = (cur_len % 2 == 1) ? 2 : 1;
    e_addr  = wr_slot * SLOT_WORDS + cur_len / 2;
    e_wdata = int'(rx_data_i) * 257;
    cur_len++;
    mode = 1;
    if (rx_last_i) begin
      mode = 0;
      if (rx_err_i) add_drop();
      else begin
        nc = 1;
        commit_len = cur_len;
      end
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk);
      if (!rst_ni) begin
        model_reset();
      end else begin
        bit new_commit;
        new_commit = 0;
        e_en = 0;
        e_we = 0;
        if (rx_valid_i) begin
          if (mode == 0) begin
            if (commit_pend || q_len.size() == NSLOT) discard_start();
            else begin
              cur_len = 0;
              accept_byte(new_commit);
            end
          end else if (mode == 1) begin
            if (cur_len == SLOT_BYTES) discard_start();
            else accept_byte(new_commit);
          end else if (rx_last_i) begin
            add_drop();
            mode = 0;
          end
        end
        if (frame_done_i && q_len.size() > 0) begin
          void'(q_len.pop_front());
          void'(q_slot.pop_front());
          rd_slot = (rd_slot + 1) % NSLOT;
        end
        if (commit_pend) begin
          q_slot.push_back(wr_slot);
          q_len.push_back(commit_len);
          wr_slot = (wr_slot + 1) % NSLOT;
        end
        commit_pend = new_commit;
      end
    end
  end

  // every-cycle comparison against the model, mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni) begin
        chk("buf_en", 32'(buf_en_o), 32'(e_en));
        chk("buf_we", 32'(buf_we_o), 32'(e_we));
        if (e_en) begin
          chk("buf_addr", 32'(buf_addr_o), 32'(e_addr));
          chk("buf_wdata", 32'(buf_wdata_o), 32'(e_wdata));
        end
        chk("frame_avail", 32'(frame_avail_o), 32'(q_len.size() != 0));
        chk("frame_slot", 32'(frame_slot_o), 32'(rd_slot));
        if (q_len.size() != 0) chk("frame_len", 32'(frame_len_o), 32'(q_len[0]));
        chk("drop_cnt", 32'(drop_cnt_o), 32'(drops));
      end
    end
  end

  // write log for literal pins
  typedef struct {int addr; int we; int wdata;} wr_t;
  wr_t wlog[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_ni && buf_en_o) wlog.push_back('{int'(buf_addr_o), int'(buf_we_o), int'(buf_wdata_o)});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rx_valid_i = 0; rx_last_i = 0; rx_err_i = 0; frame_done_i = 0;
    rst_ni = 0;
    idle(2);
    rst_ni = 1;
    idle(1);
    wlog.delete();
  endtask

  task automatic send_frame(input int n, input bit with_last, input bit err,
                            input int start, input int step);
    for (int i = 0; i < n; i++) begin
      rx_valid_i = 1;
      rx_data_i  = 8'(start + i * step);
      rx_last_i  = with_last && (i == n - 1);
      rx_err_i   = err && (i == n - 1);
      @(negedge clk);
    end
    rx_valid_i = 0; rx_last_i = 0; rx_err_i = 0;
  endtask

  task automatic pulse_done();
    frame_done_i = 1;
    @(negedge clk);
    frame_done_i = 0;
  endtask

  int exp_addr[5] = '{0, 0, 1, 1, 2};
  int exp_we[5]   = '{1, 2, 1, 2, 1};
  int exp_wd[5]   = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};

  initial begin
    // reset state
    do_reset();
    chk("rst_avail", 32'(frame_avail_o), 0);
    chk("rst_en", 32'(buf_en_o), 0);
    chk("rst_drop", 32'(drop_cnt_o), 0);
    chk("rst_len", 32'(frame_len_o), 0);

    // single 5-byte frame
    send_frame(5, 1, 0, 8'h11, 8'h11);
    chk("single_avail_early", 32'(frame_avail_o), 0);
    idle(1);
    chk("single_avail", 32'(frame_avail_o), 1);
    chk("single_slot", 32'(frame_slot_o), 0);
    chk("single_len", 32'(frame_len_o), 5);
    chk("single_nwrites", 32'(wlog.size()), 5);
    for (int i = 0; i < 5 && i < wlog.size(); i++) begin
      chk($sformatf("single_addr%0d", i), 32'(wlog[i].addr), 32'(exp_addr[i]));
      chk($sformatf("single_we%0d", i), 32'(wlog[i].we), 32'(exp_we[i]));
      chk($sformatf("single_wd%0d", i), 32'(wlog[i].wdata), 32'(exp_wd[i]));
    end

    // ring full
    do_reset();
    send_frame(20, 1, 0, 1, 3);
    idle(3);
    send_frame(30, 1, 0, 7, 5);
    idle(3);
    wlog.delete();
    send_frame(60, 1, 0, 9, 1);
    idle(3);
    chk("full_nwrites", 32'(wlog.size()), 0);
    chk("full_drop", 32'(drop_cnt_o), 1);
    chk("full_avail", 32'(frame_avail_o), 1);
    chk("full_slot", 32'(frame_slot_o), 0);
    chk("full_len", 32'(frame_len_o), 20);
    pulse_done();
    chk("full_rel_slot", 32'(frame_slot_o), 1);
    chk("full_rel_len", 32'(frame_len_o), 30);

    // oversize
    do_reset();
    send_frame(2049, 1, 0, 0, 1);
    idle(3);
    chk("over_nwrites", 32'(wlog.size()), 2048);
    if (wlog.size() == 2048) begin
      chk("over_first_addr", 32'(wlog[0].addr), 0);
      chk("over_last_addr", 32'(wlog[2047].addr), 1023);
      chk("over_last_we", 32'(wlog[2047].we), 2);
    end
    chk("over_drop", 32'(drop_cnt_o), 1);
    chk("over_avail", 32'(frame_avail_o), 0);

    // error frame, then a good frame into slot 0
    do_reset();
    send_frame(64, 1, 1, 8'h40, 1);
    idle(3);
    chk("err_nwrites", 32'(wlog.size()), 64);
    chk("err_avail", 32'(frame_avail_o), 0);
    chk("err_drop", 32'(drop_cnt_o), 1);
    wlog.delete();
    send_frame(10, 1, 0, 8'hA0, 1);
    idle(1);
    chk("err_next_avail", 32'(frame_avail_o), 1);
    chk("err_next_slot", 32'(frame_slot_o), 0);
    chk("err_next_len", 32'(frame_len_o), 10);
    if (wlog.size() > 0) chk("err_next_addr0", 32'(wlog[0].addr), 0);

    // release coinciding with commit, then release on empty ring
    do_reset();
    send_frame(8, 1, 0, 3, 1);
    idle(3);
    send_frame(12, 1, 0, 5, 2);
    frame_done_i = 1;
    @(negedge clk);
    frame_done_i = 0;
    chk("sim_avail", 32'(frame_avail_o), 1);
    chk("sim_slot", 32'(frame_slot_o), 1);
    chk("sim_len", 32'(frame_len_o), 12);
    pulse_done();
    chk("sim_empty_avail", 32'(frame_avail_o), 0);
    chk("sim_empty_slot", 32'(frame_slot_o), 0);
    pulse_done();
    chk("sim_noop_slot", 32'(frame_slot_o), 0);
    chk("sim_noop_avail", 32'(frame_avail_o), 0);

    // reset in the middle of a frame
    do_reset();
    send_frame(6, 1, 0, 1, 1);
    idle(3);
    send_frame(4, 1, 1, 2, 1);
    idle(3);
    send_frame(30, 0, 0, 8'h77, 1);
    rst_ni = 0;
    #1;
    chk("mid_rst_en", 32'(buf_en_o), 0);
    chk("mid_rst_we", 32'(buf_we_o), 0);
    chk("mid_rst_addr", 32'(buf_addr_o), 0);
    chk("mid_rst_wdata", 32'(buf_wdata_o), 0);
    chk("mid_rst_avail", 32'(frame_avail_o), 0);
    chk("mid_rst_drop", 32'(drop_cnt_o), 0);
    idle(2);
    rst_ni = 1;
    idle(1);
    send_frame(10, 1, 0, 8'h30, 1);
    idle(1);
    chk("post_rst_avail", 32'(frame_avail_o), 1);
    chk("post_rst_slot", 32'(frame_slot_o), 0);
    chk("post_rst_len", 32'(frame_len_o), 10);
    chk("post_rst_drop", 32'(drop_cnt_o), 0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
